// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the 9-bit core's fetch/run controller.
package pc_sequencer_pkg;

  // Default program counter width (instruction ROM address width).
  localparam int PC_W = 10;

  // Sequencer states: IDLE after reset, LOAD while Start is held,
  // RUN while fetching, DONE after halt or watchdog expiry.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the bench/decoder side (master) and the sequencer (slave).
//
// Program handshake: the master holds Start high to (re)load the program
// chosen by ProgSel; every cycle Start stays high the start address is
// reloaded. Dropping Start lets the sequencer enter RUN (Running=1). The run
// ends when the decoder reports the halt instruction on Ack, or when the
// watchdog fires (Timeout=1); either way Done rises and stays high until the
// next Start. Start is honoured in any state and aborts a run in progress.
interface pc_sequencer_if #(
  parameter int PC_W = pc_sequencer_pkg::PC_W
);
  import pc_sequencer_pkg::*;

  logic            Start;
  logic [1:0]      ProgSel;
  logic            Stall;
  logic            JumpEqual;
  logic            JumpNotEqual;
  logic            OffsetEn;
  logic [1:0]      PCRegSelect;
  logic [7:0]      SaveData;
  logic            ZeroFlag;
  logic            Ack;

  logic [PC_W-1:0] ProgCtr;
  logic            Running;
  logic            Done;
  logic            Timeout;
  logic [15:0]     CycleCount;
  seq_state_t      dbg_state;

  modport master (
    output Start, ProgSel, Stall, JumpEqual, JumpNotEqual, OffsetEn,
           PCRegSelect, SaveData, ZeroFlag, Ack,
    input  ProgCtr, Running, Done, Timeout, CycleCount, dbg_state
  );

  modport slave (
    input  Start, ProgSel, Stall, JumpEqual, JumpNotEqual, OffsetEn,
           PCRegSelect, SaveData, ZeroFlag, Ack,
    output ProgCtr, Running, Done, Timeout, CycleCount, dbg_state
  );

endinterface

// File: rtl/pc_save_regs.sv
// Three jump/save address registers. Select 0 means "no register": it reads
// as zero and writes to it are dropped. Clear wins over a write.
module pc_save_regs #(
  parameter int PC_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            wr_en,
  input  logic [1:0]      sel,
  input  logic [PC_W-1:0] wr_data,
  output logic [PC_W-1:0] rd_data
);

  logic [PC_W-1:0] reg1_q;
  logic [PC_W-1:0] reg2_q;
  logic [PC_W-1:0] reg3_q;

  // Register bank: async reset, synchronous clear, single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg1_q <= '0;
      reg2_q <= '0;
      reg3_q <= '0;
    end else if (clr) begin
      reg1_q <= '0;
      reg2_q <= '0;
      reg3_q <= '0;
    end else if (wr_en) begin
      case (sel)
        2'd1:    reg1_q <= wr_data;
        2'd2:    reg2_q <= wr_data;
        2'd3:    reg3_q <= wr_data;
        default: ;
      endcase
    end
  end

  // Combinational read port addressed by the same select.
  always_comb begin
    rd_data = '0;
    case (sel)
      2'd1:    rd_data = reg1_q;
      2'd2:    rd_data = reg2_q;
      2'd3:    rd_data = reg3_q;
      default: rd_data = '0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/run controller: owns ProgCtr, the jump/save registers, the program
// handshake FSM and the RUN cycle counter with its watchdog.
module pc_sequencer #(
  parameter int          PC_W       = pc_sequencer_pkg::PC_W,
  parameter int          START0     = 0,
  parameter int          START1     = 128,
  parameter int          START2     = 256,
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
  input logic           Clk,
  input logic           Reset,
  pc_sequencer_if.slave bus
);
  import pc_sequencer_pkg::*;

  seq_state_t      state_q;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     cnt_q;
  logic            running_q;
  logic            done_q;
  logic            timeout_q;

  logic [PC_W-1:0] start_addr;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_off;
  logic [PC_W-1:0] save_val;
  logic [PC_W-1:0] jump_target;
  logic            jump_any;
  logic            jump_taken;
  logic            jump_go;
  logic            last_cycle;
  logic            run_active;
  logic            advance;
  logic            save_en;
  logic            clear_regs;

  // Next-address arithmetic, jump resolution and save/clear strobes.
  always_comb begin
    start_addr = PC_W'(START0);
    case (bus.ProgSel)
      2'd1:    start_addr = PC_W'(START1);
      2'd2:    start_addr = PC_W'(START2);
      default: start_addr = PC_W'(START0);
    endcase
    // All sums wrap modulo 2^PC_W.
    pc_inc   = pc_q + PC_W'(1);
    pc_off   = pc_q + PC_W'(bus.SaveData);
    save_val = bus.OffsetEn ? pc_off : pc_inc;
    jump_any = bus.JumpEqual | bus.JumpNotEqual;
    // If both jump strobes are raised, the je condition alone decides.
    jump_taken = bus.JumpEqual ? bus.ZeroFlag
                               : (bus.JumpNotEqual & ~bus.ZeroFlag);
    jump_go    = jump_taken && (bus.PCRegSelect != 2'd0);
    last_cycle = (cnt_q == (MAX_CYCLES - 16'd1));
    run_active = (state_q == RUN) && !bus.Stall && !bus.Start;
    // Only a plain increment cycle may advance the PC or save an address.
    advance    = run_active && !bus.Ack && !last_cycle;
    save_en    = advance && !jump_any && (bus.PCRegSelect != 2'd0);
    clear_regs = (state_q == LOAD) && bus.Start;
  end

  pc_save_regs #(.PC_W(PC_W)) u_save_regs (
    .clk     (Clk),
    .rst_n   (Reset),
    .clr     (clear_regs),
    .wr_en   (save_en),
    .sel     (bus.PCRegSelect),
    .wr_data (save_val),
    .rd_data (jump_target)
  );

  // Sequencer FSM with registered ProgCtr, counter and status outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.Start) begin
            state_q   <= LOAD;
            running_q <= 1'b0;
            done_q    <= 1'b0;
          end
        end
        LOAD: begin
          if (bus.Start) begin
            pc_q      <= start_addr;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
          end else if (!bus.Stall) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          // Start aborts even a stalled cycle; otherwise Stall freezes all.
          if (!bus.Stall || bus.Start) begin
            if (!bus.Stall) cnt_q <= cnt_q + 16'd1;
            if (bus.Start) begin
              state_q   <= LOAD;
              running_q <= 1'b0;
              done_q    <= 1'b0;
            end else if (bus.Ack) begin
              state_q   <= DONE;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end else if (last_cycle) begin
              state_q   <= DONE;
              running_q <= 1'b0;
              done_q    <= 1'b1;
              timeout_q <= 1'b1;
            end else if (jump_go) begin
              pc_q <= jump_target;
            end else begin
              pc_q <= pc_inc;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
          done_q    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ProgCtr    = pc_q;
  assign bus.Running    = running_q;
  assign bus.Done       = done_q;
  assign bus.Timeout    = timeout_q;
  assign bus.CycleCount = cnt_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a vector table for the main run, plus hand-written
// sequences for async reset and the watchdog (second instance, limit 20).
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pc_sequencer_if #(.PC_W(10)) bus ();
  pc_sequencer_if #(.PC_W(10)) bus_wd ();

  pc_sequencer #(.PC_W(10)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  pc_sequencer #(.PC_W(10), .MAX_CYCLES(16'd20)) dut_wd (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus_wd)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       start;
    logic [1:0] ps;
    logic       stall;
    logic       je;
    logic       jne;
    logic       zf;
    logic [1:0] sel;
    logic       off;
    logic [7:0] sd;
    logic       ack;
    int         pc;
    logic       run;
    logic       done;
    logic       to;
    int         cnt;
  } vec_t;

  vec_t vecs[$];
  logic [9:0] exp_q[$];

  function automatic vec_t mk(logic start, logic [1:0] ps, logic stall,
                              logic je, logic jne, logic zf, logic [1:0] sel,
                              logic off, logic [7:0] sd, logic ack, int pc,
                              logic run, logic done, logic to, int cnt);
    vec_t v;
    v.start = start; v.ps = ps; v.stall = stall; v.je = je; v.jne = jne;
    v.zf = zf; v.sel = sel; v.off = off; v.sd = sd; v.ack = ack;
    v.pc = pc; v.run = run; v.done = done; v.to = to; v.cnt = cnt;
    return v;
  endfunction

  // Scoreboard compare
  task automatic chk(input string name, input int unsigned act,
                     input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input vec_t v);
    bus.Start        = v.start;
    bus.ProgSel      = v.ps;
    bus.Stall        = v.stall;
    bus.JumpEqual    = v.je;
    bus.JumpNotEqual = v.jne;
    bus.ZeroFlag     = v.zf;
    bus.PCRegSelect  = v.sel;
    bus.OffsetEn     = v.off;
    bus.SaveData     = v.sd;
    bus.Ack          = v.ack;
  endtask

  task automatic idle_wd(input logic start, input logic [1:0] ps);
    bus_wd.Start        = start;
    bus_wd.ProgSel      = ps;
    bus_wd.Stall        = 1'b0;
    bus_wd.JumpEqual    = 1'b0;
    bus_wd.JumpNotEqual = 1'b0;
    bus_wd.ZeroFlag     = 1'b0;
    bus_wd.PCRegSelect  = 2'd0;
    bus_wd.OffsetEn     = 1'b0;
    bus_wd.SaveData     = 8'd0;
    bus_wd.Ack          = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    // start ps stall je jne zf sel off sd ack | pc run done to cnt
    vecs.push_back(mk(1,1,0,0,0,0,0,0,8'd0,  0,   0,0,0,0, 0)); // 0 enter LOAD
    vecs.push_back(mk(1,1,0,0,0,0,0,0,8'd0,  0, 128,0,0,0, 0)); // 1 load 128
    vecs.push_back(mk(0,1,0,0,0,0,0,0,8'd0,  0, 128,1,0,0, 0)); // 2 RUN
    vecs.push_back(mk(0,1,0,0,0,0,0,0,8'd0,  0, 129,1,0,0, 1));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,8'd0,  0, 130,1,0,0, 2));
    vecs.push_back(mk(0,1,0,0,0,0,3,1,8'd10, 0, 131,1,0,0, 3)); // r3=140
    vecs.push_back(mk(0,1,0,1,0,1,3,0,8'd0,  0, 140,1,0,0, 4)); // je taken
    vecs.push_back(mk(0,1,0,0,0,0,2,1,8'hF0, 0, 141,1,0,0, 5)); // r2=380
    vecs.push_back(mk(0,1,0,0,1,0,2,0,8'd0,  0, 380,1,0,0, 6)); // jne taken
    vecs.push_back(mk(0,1,0,1,0,0,2,0,8'd0,  0, 381,1,0,0, 7)); // je untaken
    vecs.push_back(mk(0,1,0,1,1,0,2,0,8'd0,  0, 382,1,0,0, 8)); // both: je only
    vecs.push_back(mk(0,1,0,0,1,1,2,0,8'd0,  0, 383,1,0,0, 9)); // jne untaken
    vecs.push_back(mk(0,1,0,0,1,0,0,0,8'd0,  0, 384,1,0,0,10)); // sel 00
    vecs.push_back(mk(0,1,0,1,0,1,2,0,8'd0,  0, 380,1,0,0,11)); // r2 intact
    vecs.push_back(mk(0,1,0,0,0,0,1,1,8'd255,0, 381,1,0,0,12)); // r1=635
    vecs.push_back(mk(0,1,0,1,0,1,1,0,8'd0,  0, 635,1,0,0,13));
    vecs.push_back(mk(0,1,0,0,0,0,1,1,8'd255,0, 636,1,0,0,14)); // r1=890
    vecs.push_back(mk(0,1,0,1,0,1,1,0,8'd0,  0, 890,1,0,0,15));
    vecs.push_back(mk(0,1,0,0,0,0,1,1,8'd133,0, 891,1,0,0,16)); // r1=1023
    vecs.push_back(mk(0,1,0,1,0,1,1,0,8'd0,  0,1023,1,0,0,17));
    vecs.push_back(mk(0,1,0,0,0,0,3,1,8'd16, 0,   0,1,0,0,18)); // r3=15 trunc
    vecs.push_back(mk(0,1,0,1,0,1,1,0,8'd0,  0,1023,1,0,0,19));
    vecs.push_back(mk(0,1,0,0,0,0,1,0,8'd0,  0,   0,1,0,0,20)); // r1=0 wrap
    vecs.push_back(mk(0,1,0,0,0,0,0,0,8'd0,  0,   1,1,0,0,21));
    vecs.push_back(mk(0,1,0,1,0,1,1,0,8'd0,  0,   0,1,0,0,22)); // r1 is 0
    vecs.push_back(mk(0,1,0,1,0,1,3,0,8'd0,  0,  15,1,0,0,23)); // r3 is 15
    vecs.push_back(mk(0,1,1,0,0,0,0,0,8'd0,  0,  15,1,0,0,23)); // stall
    vecs.push_back(mk(0,1,1,0,0,0,0,0,8'd0,  1,  15,1,0,0,23)); // stall+ack
    vecs.push_back(mk(0,1,1,1,0,1,1,0,8'd0,  0,  15,1,0,0,23)); // stall+jump
    vecs.push_back(mk(0,1,0,0,0,0,2,1,8'd185,0,  16,1,0,0,24)); // r2=200
    vecs.push_back(mk(0,1,0,1,0,1,2,0,8'd0,  0, 200,1,0,0,25));
    vecs.push_back(mk(0,1,1,0,0,0,0,0,8'd0,  1, 200,1,0,0,25)); // ack stalled
    vecs.push_back(mk(0,1,0,0,0,0,0,0,8'd0,  1, 200,0,1,0,26)); // halt
    vecs.push_back(mk(0,1,0,1,0,1,1,0,8'd0,  1, 200,0,1,0,26)); // DONE holds
    vecs.push_back(mk(0,1,0,0,0,0,3,1,8'd50, 0, 200,0,1,0,26));
    vecs.push_back(mk(1,2,0,0,0,0,0,0,8'd0,  0, 200,0,0,0,26)); // restart
    vecs.push_back(mk(1,2,0,0,0,0,0,0,8'd0,  0, 256,0,0,0, 0));
    vecs.push_back(mk(0,2,0,0,0,0,0,0,8'd0,  0, 256,1,0,0, 0));
    vecs.push_back(mk(0,2,0,0,0,0,0,0,8'd0,  0, 257,1,0,0, 1));
    vecs.push_back(mk(0,2,0,1,0,1,2,0,8'd0,  0,   0,1,0,0, 2)); // r2 cleared
    vecs.push_back(mk(0,2,0,0,0,0,0,0,8'd0,  0,   1,1,0,0, 3));
    vecs.push_back(mk(0,2,0,0,0,0,1,1,8'd50, 0,   2,1,0,0, 4)); // r1=51
    vecs.push_back(mk(1,1,0,0,0,0,0,0,8'd0,  0,   2,0,0,0, 5)); // abort
    vecs.push_back(mk(1,1,0,0,0,0,0,0,8'd0,  0, 128,0,0,0, 0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,8'd0,  0, 128,1,0,0, 0));
    vecs.push_back(mk(0,1,0,1,0,1,1,0,8'd0,  0,   0,1,0,0, 1)); // r1 cleared

    rst_n = 1'b0;
    drive(mk(0,0,0,0,0,0,0,0,8'd0,0,0,0,0,0,0));
    idle_wd(1'b0, 2'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset pc",      bus.ProgCtr,    0);
    chk("reset done",    bus.Done,       1);
    chk("reset running", bus.Running,    0);
    chk("reset timeout", bus.Timeout,    0);
    chk("reset cnt",     bus.CycleCount, 0);
    chk("reset state",   bus.dbg_state,  IDLE);

    // Table-driven main run
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      tick();
      chk($sformatf("v%0d pc", i),      bus.ProgCtr,    vecs[i].pc);
      chk($sformatf("v%0d running", i), bus.Running,    vecs[i].run);
      chk($sformatf("v%0d done", i),    bus.Done,       vecs[i].done);
      chk($sformatf("v%0d timeout", i), bus.Timeout,    vecs[i].to);
      chk($sformatf("v%0d cnt", i),     bus.CycleCount, vecs[i].cnt);
    end

    // Async reset mid-RUN, checked between clock edges
    drive(mk(0,1,0,0,0,0,0,0,8'd0,0,0,0,0,0,0));
    tick();
    tick();
    chk("prereset pc",  bus.ProgCtr,    2);
    chk("prereset cnt", bus.CycleCount, 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async pc",      bus.ProgCtr,    0);
    chk("async running", bus.Running,    0);
    chk("async done",    bus.Done,       1);
    chk("async timeout", bus.Timeout,    0);
    chk("async cnt",     bus.CycleCount, 0);
    chk("async state",   bus.dbg_state,  IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    // Watchdog: limit 20 RUN cycles, program 1, no Ack
    idle_wd(1'b1, 2'd1);
    tick();
    tick();
    chk("wd load pc", bus_wd.ProgCtr, 128);
    idle_wd(1'b0, 2'd1);
    tick();
    chk("wd run", bus_wd.Running, 1);
    chk("wd run cnt", bus_wd.CycleCount, 0);
    for (int i = 1; i <= 19; i++) exp_q.push_back(10'(128 + i));
    for (int i = 1; i <= 19; i++) begin
      logic [9:0] e;
      tick();
      e = exp_q.pop_front();
      chk($sformatf("wd c%0d pc", i), bus_wd.ProgCtr, e);
      chk($sformatf("wd c%0d running", i), bus_wd.Running, 1);
    end
    chk("wd pre timeout", bus_wd.Timeout, 0);
    tick();
    chk("wd timeout",  bus_wd.Timeout,    1);
    chk("wd cnt",      bus_wd.CycleCount, 20);
    chk("wd pc",       bus_wd.ProgCtr,    147);
    chk("wd done",     bus_wd.Done,       1);
    chk("wd running",  bus_wd.Running,    0);
    chk("wd state",    bus_wd.dbg_state,  DONE);
    repeat (3) tick();
    chk("wd hold cnt", bus_wd.CycleCount, 20);
    chk("wd hold pc",  bus_wd.ProgCtr,    147);
    chk("wd hold to",  bus_wd.Timeout,    1);
    idle_wd(1'b1, 2'd0);
    tick();
    chk("wd relaunch state", bus_wd.dbg_state, LOAD);
    tick();
    chk("wd relaunch to",  bus_wd.Timeout,    0);
    chk("wd relaunch cnt", bus_wd.CycleCount, 0);
    chk("wd relaunch pc",  bus_wd.ProgCtr,    0);
    idle_wd(1'b0, 2'd0);
    tick();
    chk("wd relaunch running", bus_wd.Running, 1);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/run controller for the 9-bit core.
- Owns the program counter (ProgCtr) and the three jump/save address registers (PCreg1–PCreg3), addressed by the decoder's PCRegSelect.
- Runs the Start/Ack/Done program handshake with the bench.
- Adds a cycle counter with a watchdog timeout.
- Sits between the control decoder and the instruction ROM; drives the ROM address.

Parameters:
- PC_W, 10, program counter width.
- START0, 0, start address for program 0.
- START1, 128, start address for program 1.
- START2, 256, start address for program 2.
- MAX_CYCLES, 16'hFFFF, watchdog limit in counted RUN cycles.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  bench request: load the selected program, then run.
- ProgSel  in  2  program select; 3 maps to START0.
- Stall  in  1  hold every register this cycle.
- JumpEqual  in  1  je decoded.
- JumpNotEqual  in  1  jne decoded.
- OffsetEn  in  1  spc saves with offset.
- PCRegSelect  in  2  00 none; 01/10/11 select PCreg1/2/3.
- SaveData  in  8  r8 value (reg_file port B), used as offset.
- ZeroFlag  in  1  ALU zero flag.
- Ack  in  1  decoded halt instruction (all ones).
- ProgCtr  out  PC_W  instruction ROM address.
- Running  out  1  high in RUN.
- Done  out  1  high in IDLE and DONE.
- Timeout  out  1  sticky: watchdog fired.
- CycleCount  out  16  RUN cycles since load.

Behaviour:
- Reset (async, Reset=0):
  - state=IDLE, ProgCtr=0, PCreg1..3=0, CycleCount=0.
  - Timeout=0, Running=0, Done=1.
- States: IDLE, LOAD, RUN, DONE (enum in package).
- IDLE/DONE with Start=1 → LOAD.
- LOAD, every cycle while Start=1:
  - ProgCtr <= START[ProgSel].
  - PCreg1..3 <= 0, CycleCount <= 0, Timeout <= 0.
  - Running=0, Done=0.
- LOAD with Start=0 → RUN. First fetched instruction is at the start address.
- RUN, Stall=1: no state change at all. Stall has priority over everything except reset and Start.
- RUN, Stall=0, priority order:
  1. Start=1 → LOAD (abort; registers reinitialised next cycle).
  2. Ack=1 → DONE. ProgCtr holds at the halt instruction; no increment.
  3. CycleCount==MAX_CYCLES-1 → DONE, Timeout<=1.
  4. Jump: JumpEqual&ZeroFlag, or JumpNotEqual&!ZeroFlag, with PCRegSelect≠00 → ProgCtr <= PCreg[sel].
  5. Otherwise ProgCtr <= ProgCtr+1.
- Jump edge cases:
  - Untaken jump, or PCRegSelect=00 → ProgCtr+1.
  - JumpEqual and JumpNotEqual both high (illegal) → treat as JumpEqual only.
- Save (spc): no jump signal, PCRegSelect≠00, Stall=0 → PCreg[sel] updated in the same cycle as ProgCtr+1.
  - OffsetEn=0: saved value = ProgCtr+1.
  - OffsetEn=1: saved value = ProgCtr + zero-extended SaveData.
- CycleCount increments on each non-stalled RUN cycle, including the Ack cycle. It freezes in DONE.
- Arithmetic is modulo 2^PC_W. ProgCtr+1 at all-ones wraps to 0; offset sums truncate to PC_W bits.
- DONE:
  - ProgCtr, CycleCount and Timeout hold; Done=1.
  - Ack, jump and save inputs are ignored.
- Reset mid-RUN: immediate async return to the reset values above.

Decomposition:
- Package definitions: typedef enum logic[1:0] seq_state_t {IDLE, LOAD, RUN, DONE}; localparam PC_W.
- Sub-module pc_save_regs: 3×PC_W registers with async active-low reset, synchronous clear, one write port (sel, en, data) and a combinational read by sel. Index 00 reads 0 and ignores writes.
- pc_sequencer holds the FSM, ProgCtr, jump/save arithmetic and the counter.

Test Plan:
- Reset → ProgCtr=0, Done=1. Start=1, ProgSel=1 for 2 cycles, then 0 → ProgCtr=128, Running=1; ProgCtr 129, 130 on the next cycles.
- At PC=140: spc PCRegSelect=10, OffsetEn=1, SaveData=8'hF0 → PCreg2=380. Later jne with ZeroFlag=0 → ProgCtr=380. je with ZeroFlag=0 → ProgCtr+1.
- spc PCRegSelect=01, OffsetEn=0 at PC=1023 → PCreg1=0, ProgCtr wraps to 0.
- Stall=1 for 3 cycles mid-run → ProgCtr and CycleCount unchanged. Ack with Stall=1 is ignored; Ack at PC=200 with Stall=0 → DONE, ProgCtr=200, Done=1.
- MAX_CYCLES=20, program with no Ack → DONE after 20 RUN cycles, Timeout=1, CycleCount=20. New Start clears Timeout.
- Start raised mid-RUN → LOAD, PCregs=0. Reset dropped mid-RUN → all outputs at reset values with no clock edge needed.
